// File: rtl/pll_reconfig_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pll_reconfig_ctrl
// Description : Initiator for PLL dynamic reconfiguration. It applies the
//               divider, duty and phase values, pulses pll_rst, and then waits
//               for a filtered lock, with timeout and retry handling.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reconfig_ctrl #(
    parameter int DIV_W        = 10,
    parameter int PHASE_W      = 13,
    parameter int DEF_ODIV     = 100,
    parameter int DEF_DUTY     = 100,
    parameter int DEF_PHASE    = 16,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_FILTER  = 8,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int TO_W         = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [DIV_W-1:0]   cfg_odiv,
    input  logic [DIV_W-1:0]   cfg_duty,
    input  logic [PHASE_W-1:0] cfg_phase,
    input  logic               pll_lock,
    output logic               pll_rst,
    output logic [DIV_W-1:0]   dyn_odiv,
    output logic [DIV_W-1:0]   dyn_duty,
    output logic [PHASE_W-1:0] dyn_phase,
    output logic               locked,
    output logic               done,
    output logic               err,
    output logic               lock_lost,
    output logic               fail
);

    localparam int c_FC_W = $clog2(LOCK_FILTER + 1);
    localparam int c_RC_W = $clog2(RST_CYCLES);
    localparam int c_RT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [c_FC_W-1:0] c_FILT_MAX  = c_FC_W'(LOCK_FILTER);
    localparam logic [c_RC_W-1:0] c_RST_LAST  = c_RC_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]   c_TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_RT_W-1:0] c_MAX_RETRY = c_RT_W'(MAX_RETRY);

    localparam logic [1:0] c_S_RESET_PLL = 2'd0;
    localparam logic [1:0] c_S_WAIT_LOCK = 2'd1;
    localparam logic [1:0] c_S_RUN       = 2'd2;
    localparam logic [1:0] c_S_FAIL      = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               r_sync1;
    logic               r_lock_s;
    logic [c_FC_W-1:0]  r_filt_cnt;
    logic [c_RC_W-1:0]  r_rst_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [c_RT_W-1:0]  r_retry;
    logic [c_RT_W-1:0]  w_retry_next;
    logic               r_pll_rst;
    logic               r_cfg_ready;
    logic               r_fail;
    logic               w_fail_next;
    logic [DIV_W-1:0]   r_dyn_odiv;
    logic [DIV_W-1:0]   r_dyn_duty;
    logic [PHASE_W-1:0] r_dyn_phase;
    logic               w_lock_ok;
    logic               w_load;
    logic               w_done;
    logic               w_err;
    logic               w_lock_lost;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= pll_lock;
            r_lock_s <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt_cnt <= '0;
        end else if (r_pll_rst || !r_lock_s) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt != c_FILT_MAX) begin
            r_filt_cnt <= r_filt_cnt + c_FC_W'(1);
        end
    end

    // A low lock_s counts as an empty filter at once, so a drop is seen
    // without waiting for the counter to clear.
    assign w_lock_ok = r_lock_s && (r_filt_cnt == c_FILT_MAX);

    always_comb begin
        w_next_state = r_state;
        w_retry_next = r_retry;
        w_fail_next  = r_fail;
        w_load       = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_lock_lost  = 1'b0;
        case (r_state)
            c_S_RESET_PLL: begin
                if (r_rst_cnt == c_RST_LAST) begin
                    w_next_state = c_S_WAIT_LOCK;
                end
            end
            c_S_WAIT_LOCK: begin
                if (w_lock_ok) begin
                    w_done       = 1'b1;
                    w_retry_next = '0;
                    w_fail_next  = 1'b0;
                    w_next_state = c_S_RUN;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_err = 1'b1;
                    if (r_retry < c_MAX_RETRY) begin
                        w_retry_next = r_retry + c_RT_W'(1);
                        w_next_state = c_S_RESET_PLL;
                    end else begin
                        w_fail_next  = 1'b1;
                        w_next_state = c_S_FAIL;
                    end
                end
            end
            c_S_RUN: begin
                w_lock_lost = !w_lock_ok;
                if (cfg_valid && r_cfg_ready) begin
                    w_load       = 1'b1;
                    w_next_state = c_S_RESET_PLL;
                end else if (!w_lock_ok) begin
                    w_next_state = c_S_RESET_PLL;
                end
            end
            c_S_FAIL: begin
                if (cfg_valid && r_cfg_ready) begin
                    w_load       = 1'b1;
                    w_retry_next = '0;
                    w_next_state = c_S_RESET_PLL;
                end
            end
            default: begin
                w_next_state = c_S_RESET_PLL;
            end
        endcase
    end

    // Both counters restart on every state change so neither can wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_cnt <= '0;
            r_to_cnt  <= '0;
        end else if (w_next_state != r_state) begin
            r_rst_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (r_state == c_S_RESET_PLL) begin
                r_rst_cnt <= r_rst_cnt + c_RC_W'(1);
            end
            if (r_state == c_S_WAIT_LOCK) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_RESET_PLL;
            r_retry     <= '0;
            r_pll_rst   <= 1'b1;
            r_cfg_ready <= 1'b0;
            r_fail      <= 1'b0;
            r_dyn_odiv  <= DIV_W'(DEF_ODIV);
            r_dyn_duty  <= DIV_W'(DEF_DUTY);
            r_dyn_phase <= PHASE_W'(DEF_PHASE);
        end else begin
            r_state     <= w_next_state;
            r_retry     <= w_retry_next;
            r_pll_rst   <= (w_next_state == c_S_RESET_PLL);
            r_cfg_ready <= (w_next_state == c_S_RUN) || (w_next_state == c_S_FAIL);
            r_fail      <= w_fail_next;
            if (w_load) begin
                r_dyn_odiv  <= cfg_odiv;
                r_dyn_duty  <= cfg_duty;
                r_dyn_phase <= cfg_phase;
            end
        end
    end

    assign pll_rst   = r_pll_rst;
    assign cfg_ready = r_cfg_ready;
    assign fail      = r_fail;
    assign dyn_odiv  = r_dyn_odiv;
    assign dyn_duty  = r_dyn_duty;
    assign dyn_phase = r_dyn_phase;
    assign locked    = (r_state == c_S_RUN) && w_lock_ok;
    assign done      = w_done;
    assign err       = w_err;
    assign lock_lost = w_lock_lost;

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pll_reconfig_ctrl
// Description : Self-checking bench for pll_reconfig_ctrl: directed vectors,
//               corner sequences and a randomized run against a reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reconfig_ctrl;

    localparam int P_RST   = 4;
    localparam int P_FILT  = 3;
    localparam int P_TO    = 50;
    localparam int P_RETRY = 2;

    localparam int M_RESET = 0;
    localparam int M_WAIT  = 1;
    localparam int M_RUN   = 2;
    localparam int M_FAIL  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [9:0]  cfg_odiv = '0;
    logic [9:0]  cfg_duty = '0;
    logic [12:0] cfg_phase = '0;
    logic        pll_lock = 1'b0;
    logic        pll_rst;
    logic [9:0]  dyn_odiv;
    logic [9:0]  dyn_duty;
    logic [12:0] dyn_phase;
    logic        locked;
    logic        done;
    logic        err;
    logic        lock_lost;
    logic        fail;

    int checks = 0;
    int failures = 0;

    pll_reconfig_ctrl #(
        .DIV_W(10), .PHASE_W(13), .DEF_ODIV(100), .DEF_DUTY(100), .DEF_PHASE(16),
        .RST_CYCLES(P_RST), .LOCK_FILTER(P_FILT), .LOCK_TIMEOUT(P_TO), .TO_W(16),
        .MAX_RETRY(P_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_odiv(cfg_odiv), .cfg_duty(cfg_duty), .cfg_phase(cfg_phase),
        .pll_lock(pll_lock), .pll_rst(pll_rst), .dyn_odiv(dyn_odiv),
        .dyn_duty(dyn_duty), .dyn_phase(dyn_phase), .locked(locked),
        .done(done), .err(err), .lock_lost(lock_lost), .fail(fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Counts pll_rst high cycles from the current one, then drives the lock
    // pattern in WAIT_LOCK and reports the cycle index of done or err.
    task automatic run_seq(input int lock_at, input int glitch_at, output int rst_len,
                           output int lat, output bit got_done, output bit got_err);
        rst_len = 0; lat = -1; got_done = 0; got_err = 0;
        while (pll_rst && rst_len < 100) begin
            rst_len++;
            nxt();
        end
        for (int k = 0; k < 200; k++) begin
            if (glitch_at >= 0 && k == glitch_at) pll_lock = 1'b1;
            if (glitch_at >= 0 && k == glitch_at + 2) pll_lock = 1'b0;
            if (k == lock_at) pll_lock = 1'b1;
            if (k == 3) begin cfg_valid = 1'b1; cfg_odiv = 10'd7; end
            if (k == 4) cfg_valid = 1'b0;
            if (done || err) begin
                got_done = done; got_err = err; lat = k;
                break;
            end
            nxt();
        end
    endtask

    typedef struct {
        logic [9:0]  odiv;
        logic [9:0]  duty;
        logic [12:0] phase;
        int          lock_at;
        logic [9:0]  exp_odiv;
        logic [9:0]  exp_duty;
        logic [12:0] exp_phase;
        int          exp_rst;
        int          exp_lat;
    } vec_t;
    vec_t tbl[4];

    // Reference: mode and time-in-mode, with lock derived from sample history.
    int m_mode, m_time, m_retry;
    bit m_fail;
    logic [9:0]  m_odiv, m_duty;
    logic [12:0] m_phase;
    bit lk_q[$];
    bit good_q[$];

    task automatic m_reset();
        m_mode = M_RESET; m_time = 0; m_retry = 0; m_fail = 0;
        m_odiv = 10'd100; m_duty = 10'd100; m_phase = 13'd16;
        lk_q.delete(); good_q.delete();
    endtask

    function automatic bit m_lock_s();
        int t;
        t = lk_q.size();
        return (t >= 2) ? lk_q[t-2] : 1'b0;
    endfunction

    function automatic bit m_lock_ok();
        int n;
        n = 0;
        for (int i = good_q.size() - 1; i >= 0; i--) begin
            if (!good_q[i]) break;
            n++;
            if (n == P_FILT) break;
        end
        return m_lock_s() && (n == P_FILT);
    endfunction

    task automatic m_enter(input int mode);
        m_mode = mode; m_time = 0;
    endtask

    task automatic m_load();
        m_odiv = cfg_odiv; m_duty = cfg_duty; m_phase = cfg_phase;
    endtask

    task automatic m_step();
        bit ok;
        ok = m_lock_ok();
        good_q.push_back(m_lock_s() && (m_mode != M_RESET));
        lk_q.push_back(pll_lock);
        m_time++;
        case (m_mode)
            M_RESET: if (m_time == P_RST) m_enter(M_WAIT);
            M_WAIT: begin
                if (ok) begin
                    m_retry = 0; m_fail = 0; m_enter(M_RUN);
                end else if (m_time == P_TO) begin
                    if (m_retry < P_RETRY) begin m_retry++; m_enter(M_RESET); end
                    else begin m_fail = 1; m_enter(M_FAIL); end
                end
            end
            M_RUN: begin
                if (cfg_valid) begin m_load(); m_enter(M_RESET); end
                else if (!ok) m_enter(M_RESET);
            end
            M_FAIL: if (cfg_valid) begin m_load(); m_retry = 0; m_enter(M_RESET); end
            default: ;
        endcase
    endtask

    initial begin
        int rl, lat, pulses, since, lock_at, k;
        bit gd, ge, ok;
        logic [39:0] act, exp;

        tbl[0] = '{10'd200,  10'd200, 13'd16,   10, 10'd200,  10'd200, 13'd16,   4, 15};
        tbl[1] = '{10'd1023, 10'd0,   13'd8191, 0,  10'd1023, 10'd0,   13'd8191, 4, 5};
        tbl[2] = '{10'd1,    10'd512, 13'd4096, 44, 10'd1,    10'd512, 13'd4096, 4, 49};
        tbl[3] = '{10'd300,  10'd50,  13'd1,    25, 10'd300,  10'd50,  13'd1,    4, 30};

        repeat (3) nxt();
        chk("rst_pll_rst", 64'(pll_rst), 64'(1));
        chk("rst_dyn_odiv", 64'(dyn_odiv), 64'(100));
        chk("rst_dyn_duty", 64'(dyn_duty), 64'(100));
        chk("rst_dyn_phase", 64'(dyn_phase), 64'(16));
        chk("rst_outputs", 64'({cfg_ready, locked, done, err, lock_lost, fail}), 64'(0));

        rst = 1'b0;
        run_seq(10, -1, rl, lat, gd, ge);
        chk("pwrup_rst_len", 64'(rl), 64'(4));
        chk("pwrup_done", 64'(gd), 64'(1));
        chk("pwrup_done_lat", 64'(lat), 64'(15));
        nxt();
        chk("pwrup_run", 64'({locked, cfg_ready, done}), 64'(3'b110));
        chk("pwrup_odiv", 64'(dyn_odiv), 64'(100));

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("vec%0d_ready", i), 64'(cfg_ready), 64'(1));
            cfg_valid = 1'b1; cfg_odiv = tbl[i].odiv; cfg_duty = tbl[i].duty;
            cfg_phase = tbl[i].phase; pll_lock = 1'b0;
            nxt();
            cfg_valid = 1'b0;
            chk($sformatf("vec%0d_odiv", i), 64'(dyn_odiv), 64'(tbl[i].exp_odiv));
            chk($sformatf("vec%0d_duty", i), 64'(dyn_duty), 64'(tbl[i].exp_duty));
            chk($sformatf("vec%0d_phase", i), 64'(dyn_phase), 64'(tbl[i].exp_phase));
            chk($sformatf("vec%0d_rst_ready", i), 64'({pll_rst, cfg_ready}), 64'(2'b10));
            run_seq(tbl[i].lock_at, -1, rl, lat, gd, ge);
            chk($sformatf("vec%0d_rst_len", i), 64'(rl), 64'(tbl[i].exp_rst));
            chk($sformatf("vec%0d_done", i), 64'({gd, ge}), 64'(2'b10));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].exp_lat));
            nxt();
            chk($sformatf("vec%0d_locked", i), 64'(locked), 64'(1));
            chk($sformatf("vec%0d_odiv_kept", i), 64'(dyn_odiv), 64'(tbl[i].exp_odiv));
        end

        // Lock loss in RUN
        pll_lock = 1'b0; k = 0;
        while (!lock_lost && k < 10) begin nxt(); k++; end
        chk("ll_delay", 64'(k), 64'(2));
        chk("ll_locked", 64'(locked), 64'(0));
        nxt();
        chk("ll_pulse", 64'({lock_lost, pll_rst}), 64'(2'b01));
        chk("ll_dyn_odiv", 64'(dyn_odiv), 64'(300));
        run_seq(10, -1, rl, lat, gd, ge);
        chk("ll_relock", 64'({64'(rl), 64'(lat)} == {64'(4), 64'(15)}), 64'(1));
        nxt();

        // Timeout, retries, FAIL, recovery
        cfg_valid = 1'b1; cfg_odiv = 10'd200; cfg_duty = 10'd200; cfg_phase = 13'd16;
        pll_lock = 1'b0;
        nxt();
        cfg_valid = 1'b0;
        pulses = 0;
        for (int a = 0; a < 3; a++) begin
            run_seq(-1, (a == 0) ? 5 : -1, rl, lat, gd, ge);
            if (rl > 0) pulses++;
            chk($sformatf("to%0d_err", a), 64'({gd, ge}), 64'(2'b01));
            chk($sformatf("to%0d_lat", a), 64'(lat), 64'(49));
            nxt();
            chk($sformatf("to%0d_err_width", a), 64'(err), 64'(0));
            if (a < 2) chk($sformatf("to%0d_retry_rst", a), 64'(pll_rst), 64'(1));
        end
        chk("to_reset_pulses", 64'(pulses), 64'(3));
        chk("to_fail", 64'({fail, cfg_ready, pll_rst}), 64'(3'b110));
        repeat (3) nxt();
        chk("to_fail_hold", 64'(fail), 64'(1));
        cfg_valid = 1'b1; cfg_odiv = 10'd55;
        nxt();
        cfg_valid = 1'b0;
        chk("fail_restart", 64'({pll_rst, fail}), 64'(2'b11));
        chk("fail_restart_odiv", 64'(dyn_odiv), 64'(55));
        run_seq(10, -1, rl, lat, gd, ge);
        chk("fail_relock_lat", 64'(lat), 64'(15));
        nxt();
        chk("fail_cleared", 64'({fail, locked}), 64'(2'b01));

        // Asynchronous reset in the middle of WAIT_LOCK
        cfg_valid = 1'b1; cfg_odiv = 10'd200; pll_lock = 1'b0;
        nxt();
        cfg_valid = 1'b0;
        repeat (6) nxt();
        chk("ar_in_wait", 64'({pll_rst, dyn_odiv}), 64'({1'b0, 10'd200}));
        #2 rst = 1'b1;
        #1;
        chk("ar_pll_rst", 64'(pll_rst), 64'(1));
        chk("ar_dyn", 64'({dyn_odiv, dyn_duty}), 64'({10'd100, 10'd100}));
        chk("ar_ready", 64'(cfg_ready), 64'(0));
        nxt();

        // Randomized run against the reference
        nxt();
        m_reset();
        rst = 1'b0; cfg_valid = 1'b0; pll_lock = 1'b0;
        since = 0; lock_at = 0;
        for (int t = 0; t < 3000 && failures < 50; t++) begin
            if (t > 0) begin
                nxt();
                m_step();
            end
            ok = m_lock_ok();
            exp = {m_mode == M_RESET, m_mode == M_RUN || m_mode == M_FAIL,
                   m_mode == M_RUN && ok, m_mode == M_WAIT && ok,
                   m_mode == M_WAIT && !ok && m_time == P_TO - 1,
                   m_mode == M_RUN && !ok, m_fail, m_odiv, m_duty, m_phase};
            act = {pll_rst, cfg_ready, locked, done, err, lock_lost, fail,
                   dyn_odiv, dyn_duty, dyn_phase};
            chk($sformatf("rand_t%0d", t), 64'(act), 64'(exp));
            cfg_valid = ($urandom_range(0, 99) < 6);
            cfg_odiv  = 10'($urandom);
            cfg_duty  = 10'($urandom);
            cfg_phase = 13'($urandom);
            if (pll_rst) begin
                pll_lock = 1'b0; since = 0;
                lock_at = ($urandom_range(0, 99) < 15) ? 100000 : int'($urandom_range(0, 45));
            end else begin
                since++;
                if (since >= lock_at) pll_lock = ($urandom_range(0, 199) != 0);
                else pll_lock = ($urandom_range(0, 29) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
Initiator side of the PLL dynamic-configuration interface. It owns pll_rst and the dyn_odiv/dyn_duty/dyn_phase buses, and sequences each reconfiguration as: apply values, pulse pll_rst, wait for filtered pll_lock. It reports completion, timeout and lock loss to the system controller. It sits between the board control logic and the pll_sft instance.

Parameters:
DIV_W, 10, width of odiv/duty buses
PHASE_W, 13, width of phase bus
DEF_ODIV, 100, dyn_odiv value after reset
DEF_DUTY, 100, dyn_duty value after reset
DEF_PHASE, 16, dyn_phase value after reset
RST_CYCLES, 16, pll_rst high time in clk cycles (>=2)
LOCK_FILTER, 8, consecutive synchronized-high cycles for lock to count as valid (>=1)
LOCK_TIMEOUT, 65535, max cycles in WAIT_LOCK before timeout (<2^TO_W)
TO_W, 16, timeout counter width
MAX_RETRY, 3, automatic re-resets after a timeout before entering FAIL

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cfg_valid  in  1  new configuration request
cfg_ready  out  1  controller can accept a request
cfg_odiv  in  DIV_W  requested output divider
cfg_duty  in  DIV_W  requested duty setting
cfg_phase  in  PHASE_W  requested phase setting
pll_lock  in  1  PLL lock, asynchronous to clk
pll_rst  out  1  PLL reset, active high
dyn_odiv  out  DIV_W  divider to PLL
dyn_duty  out  DIV_W  duty to PLL
dyn_phase  out  PHASE_W  phase to PLL
locked  out  1  filtered lock status
done  out  1  one-cycle pulse when a sequence reaches lock
err  out  1  one-cycle pulse on each lock timeout
lock_lost  out  1  one-cycle pulse when lock drops in RUN
fail  out  1  level, set when retries are exhausted

Behaviour:
- Reset values: state=RESET_PLL, pll_rst=1, dyn_*=DEF_*, cfg_ready=0, locked=0, done=err=lock_lost=fail=0, retry count=0, all counters=0.
- pll_lock passes through a 2-FF synchronizer. lock_s is the second-stage output.
- Filter counter: cleared whenever lock_s=0, increments while lock_s=1, saturates at LOCK_FILTER. lock_ok = (count==LOCK_FILTER). The counter is also cleared while pll_rst=1.
- States:
  - RESET_PLL: pll_rst=1 for exactly RST_CYCLES cycles counted from entry, then WAIT_LOCK. pll_rst drops on the same edge as the transition.
  - WAIT_LOCK: pll_rst=0 and the timeout counter increments.
    - lock_ok: go to RUN. done=1 for one cycle. Retry count cleared. fail cleared.
    - Counter reaches LOCK_TIMEOUT with no lock_ok: err=1 for one cycle. If retry<MAX_RETRY, retry+1 and go to RESET_PLL; otherwise go to FAIL.
    - lock_ok has priority over timeout on the same cycle.
  - RUN: locked=1, cfg_ready=1.
    - cfg_valid&cfg_ready: latch cfg_* into dyn_* on that edge and go to RESET_PLL. New values and pll_rst=1 appear on the same cycle.
    - lock_ok falls: lock_lost=1 for one cycle, locked=0, go to RESET_PLL with dyn_* unchanged.
    - A simultaneous request and lock loss is treated as the request accepted: lock_lost is still pulsed, then one RESET_PLL sequence runs with the new values.
  - FAIL: fail=1, pll_rst=0, cfg_ready=1. cfg_valid loads new values, clears retry and enters RESET_PLL. fail stays high until the next done.
- cfg_ready=0 in RESET_PLL and WAIT_LOCK; requests there are ignored and not queued.
- locked=1 only in RUN.
- Asynchronous rst mid-sequence returns all registers to reset values immediately. dyn_* revert to DEF_*.
- Counters never wrap: the RST and timeout counters are cleared on every state entry.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_FILTER=3, LOCK_TIMEOUT=50, MAX_RETRY=2, DEF_ODIV=100.
1. Power-up: release rst, model raises pll_lock 10 cycles after pll_rst falls -> pll_rst high for exactly 4 cycles, dyn_odiv=100, done pulse 5 cycles after lock rises (2 sync + 3 filter), then locked=1 and cfg_ready=1.
2. Reconfig: in RUN send cfg_odiv=200, cfg_duty=200, cfg_phase=16 -> same edge gives dyn_odiv=200 and pll_rst=1 for 4 cycles, cfg_ready=0 until the next done.
3. Timeout/retry: hold pll_lock=0 -> err pulses after 50 cycles of WAIT_LOCK, 3 total reset pulses, then fail=1 and cfg_ready=1. A new cfg_valid then restarts the sequence; a subsequent lock gives done and fail=0.
4. Glitch filter: pulse pll_lock high for 2 cycles during WAIT_LOCK -> no done, timeout counter keeps running.
5. Lock loss: drop pll_lock in RUN -> lock_lost one cycle exactly 2 cycles after the drop, locked=0, pll_rst re-asserted, dyn_* unchanged.
6. Async reset mid-WAIT_LOCK after reconfig to 200 -> dyn_odiv=100 and pll_rst=1 immediately, without waiting for a clk edge.
